// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// SRAM-like instruction bus between the fetch stage (master) and the
// instruction memory or cache (slave). At most one request is outstanding.
//
// Signals
//   inst_req      master->slave  request valid
//   inst_wr       master->slave  write enable (fetch only reads, always 0)
//   inst_size     master->slave  access size (always 2'd2, one word)
//   inst_addr     master->slave  request address
//   inst_wdata    master->slave  write data (unused, always 0)
//   inst_addr_ok  slave->master  request accepted this cycle
//   inst_data_ok  slave->master  read data valid this cycle
//   inst_rdata    slave->master  read data
// ---------------------------------------------------------------------------
interface inst_fetch_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. Issues one word read per instruction on an
// SRAM-like bus, holds the returned word for decode until it is accepted,
// and stalls the PC register until that hand-off happens. A flush discards
// any fetch in progress; data already requested is swallowed when it returns.
//
// Optional feature: define IF_ADEL_CHECK_EN to flag misaligned fetch
// addresses locally (no bus request) with if_adel instead of issuing them.
//
// Ports
//   clk, resetn   clock and synchronous active-low reset
//   npc           fetch address from the PC register
//   flush         redirect: abandon all fetch work
//   id_allow      decode accepts if_inst this cycle
//   bus           instruction bus master (inst_fetch_if.master)
//   if_valid      if_pc/if_inst hold a fetched instruction
//   if_pc         address of the presented instruction
//   if_inst       presented instruction word (NOP_INST when not valid)
//   if_adel       fetch address error for if_pc
//   if_stall      hold the PC register
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [31:0]         npc,
    input  logic                flush,
    input  logic                id_allow,
    inst_fetch_if.master        bus,
    output logic                if_valid,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_inst,
    output logic                if_adel,
    output logic                if_stall
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} stateT;

    stateT       state_q,  state_d;
    logic [31:0] reqPc_q,  reqPc_d;
    logic        cancel_q, cancel_d;
    logic [31:0] ifPc_q,   ifPc_d;
    logic [31:0] ifInst_q, ifInst_d;
`ifdef IF_ADEL_CHECK_EN
    logic        ifAdel_q, ifAdel_d;
`endif

    // State register: every piece of fetch state updates here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            reqPc_q  <= 32'h0;
            cancel_q <= 1'b0;
            ifPc_q   <= 32'h0;
            ifInst_q <= NOP_INST;
`ifdef IF_ADEL_CHECK_EN
            ifAdel_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            reqPc_q  <= reqPc_d;
            cancel_q <= cancel_d;
            ifPc_q   <= ifPc_d;
            ifInst_q <= ifInst_d;
`ifdef IF_ADEL_CHECK_EN
            ifAdel_q <= ifAdel_d;
`endif
        end
    end

    // Next-state logic. cancel remembers that the outstanding request was
    // flushed after the slave accepted it, so its data must be dropped.
    always_comb begin
        state_d  = state_q;
        reqPc_d  = reqPc_q;
        cancel_d = cancel_q;
        ifPc_d   = ifPc_q;
        ifInst_d = ifInst_q;
`ifdef IF_ADEL_CHECK_EN
        ifAdel_d = ifAdel_q;
`endif
        case (state_q)
            IDLE: begin
                if (!flush) begin
                    reqPc_d = npc;
`ifdef IF_ADEL_CHECK_EN
                    // Misaligned fetch never reaches the bus; the error is
                    // handed to decode as a NOP carrying the bad PC.
                    if (npc[1:0] != 2'b00) begin
                        state_d  = FULL;
                        ifPc_d   = npc;
                        ifInst_d = NOP_INST;
                        ifAdel_d = 1'b1;
                    end else begin
                        state_d  = REQ;
                    end
`else
                    state_d = REQ;
`endif
                end
            end
            REQ: begin
                if (bus.inst_addr_ok) begin
                    state_d  = WAIT;
                    cancel_d = flush;
                end else if (flush) begin
                    state_d  = IDLE;
                end
            end
            WAIT: begin
                if (bus.inst_data_ok) begin
                    if (cancel_q || flush) begin
                        cancel_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        ifInst_d = bus.inst_rdata;
                        ifPc_d   = reqPc_q;
`ifdef IF_ADEL_CHECK_EN
                        ifAdel_d = 1'b0;
`endif
                        state_d  = FULL;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            FULL: begin
                if (flush || id_allow) begin
                    state_d  = IDLE;
`ifdef IF_ADEL_CHECK_EN
                    ifAdel_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. reqPc only changes in IDLE, which keeps inst_addr stable for
    // the whole REQ phase. The PC may only advance on an actual hand-off.
    always_comb begin
        bus.inst_req   = (state_q == REQ);
        bus.inst_wr    = 1'b0;
        bus.inst_size  = 2'd2;
        bus.inst_addr  = reqPc_q;
        bus.inst_wdata = 32'h0;
        if_valid       = (state_q == FULL);
        if_pc          = ifPc_q;
        if_inst        = (state_q == FULL) ? ifInst_q : NOP_INST;
`ifdef IF_ADEL_CHECK_EN
        if_adel        = ifAdel_q;
`else
        if_adel        = 1'b0;
`endif
        if_stall       = !resetn || !((state_q == FULL) && id_allow);
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, instruction word presented on if_inst when no valid instruction is held.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 npc  in  32  fetch address from the PC register.
REQ-005 flush  in  1  redirect (exception, eret or branch-taken); discards all fetch work.
REQ-006 id_allow  in  1  decode stage accepts if_inst this cycle.
REQ-007 inst_req  out  1  SRAM-like request valid.
REQ-008 inst_wr, inst_size, inst_wdata  out  1/2/32  tied 0 / 2'd2 / 32'h0.
REQ-009 inst_addr  out  32  request address.
REQ-010 inst_addr_ok  in  1  request accepted this cycle.
REQ-011 inst_data_ok, inst_rdata  in  1/32  read data returned this cycle.
REQ-012 if_valid, if_pc, if_inst  out  1/32/32  fetched instruction to decode.
REQ-013 if_adel  out  1  fetch address-error flag for if_pc.
REQ-014 if_stall  out  1  holds the PC register.

Function
REQ-015 FSM states IDLE, REQ, WAIT, FULL; exactly one request outstanding at any time.
REQ-016 IDLE: if !flush, latch req_pc<=npc and go to REQ; if flush, stay in IDLE.
REQ-017 REQ: inst_req=1, inst_addr=req_pc, both held stable until inst_addr_ok.
REQ-018 REQ & inst_addr_ok & !flush -> WAIT; REQ & inst_addr_ok & flush -> WAIT with cancel=1.
REQ-019 REQ & flush & !inst_addr_ok -> IDLE; inst_req low from next cycle.
REQ-020 WAIT & inst_data_ok & !cancel & !flush -> if_inst<=inst_rdata, if_pc<=req_pc, if_valid<=1, FULL.
REQ-021 WAIT & inst_data_ok & (cancel|flush) -> data dropped, cancel<=0, IDLE.
REQ-022 WAIT & flush & !inst_data_ok -> cancel<=1, stay in WAIT.
REQ-023 inst_data_ok outside WAIT is ignored.
REQ-024 FULL & id_allow & !flush -> if_valid<=0, IDLE; FULL & flush -> if_valid<=0, IDLE; otherwise hold all outputs.
REQ-025 if_valid=1 only in FULL; in other states if_inst=NOP_INST.
REQ-026 if_stall=!(state==FULL & id_allow): the PC advances exactly once per handed-off instruction (PC gives flush-redirect priority over stall).
REQ-027 Delivery latency with zero-wait slave (addr_ok in first REQ cycle, data_ok next cycle): IDLE->REQ->WAIT->FULL, if_valid 3 cycles after npc latched.

Reset
REQ-028 On resetn=0 at posedge clk: state IDLE, inst_req 0, inst_addr 0, req_pc 0, cancel 0, if_valid 0, if_pc 0, if_inst NOP_INST, if_adel 0.
REQ-029 Reset during WAIT abandons the transaction; first request after reset uses npc at that time.
REQ-030 if_stall=1 during reset.

Configuration
REQ-031 Macro IF_ADEL_CHECK_EN defined: in IDLE with npc[1:0]!=0 and !flush, no bus request; next cycle FULL with if_valid=1, if_adel=1, if_pc=npc, if_inst=NOP_INST.
REQ-032 Macro IF_ADEL_CHECK_EN undefined: if_adel tied 0; all addresses issued unchanged.

Verification
REQ-033 Reset, npc=32'hbfc0_0000, zero-wait slave returning 32'h2408_0001 -> inst_addr=bfc0_0000 while inst_req, if_valid=1 with if_pc=bfc0_0000, if_inst=2408_0001, 3 cycles after npc latched.
REQ-034 Slave holds addr_ok low 4 cycles -> inst_req and inst_addr stable all 4 cycles; single transaction issued.
REQ-035 flush in WAIT before data_ok (rdata 32'hdead_beef) -> data discarded, if_valid stays 0, next request at new npc.
REQ-036 FULL with id_allow=0 for 3 cycles -> if_valid, if_pc, if_inst held and if_stall=1; id_allow=1 -> if_stall=0 for exactly 1 cycle.
REQ-037 With IF_ADEL_CHECK_EN, npc=32'hbfc0_0002 -> no inst_req, if_valid=1, if_adel=1, if_pc=bfc0_0002.
REQ-038 flush coincident with inst_addr_ok -> cancel set, following data_ok dropped, FSM returns to IDLE.
